// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding and branch-membership constants
package jtag_pkg;

  localparam int TAP_STATE_W = 4;

  // Standard 1149.1 state encodings
  typedef enum logic [TAP_STATE_W-1:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  // One bit per state code: set when that state belongs to the branch.
  // IR branch: SEL_IR, EX2_IR, EX1_IR, SH_IR, PAU_IR, UPD_IR, CAP_IR
  localparam logic [15:0] IR_BRANCH = 16'h6F10;
  // DR branch: EX2_DR, EX1_DR, SH_DR, PAU_DR, UPD_DR, CAP_DR, SEL_DR
  localparam logic [15:0] DR_BRANCH = 16'h00EF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP state register and next-state logic
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_q;
  tap_state_t state_d;

  // State register: advances on TCK rise, asynchronously forced to TLR
  always_ff @(posedge tck or posedge rst) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_d;
  end

  // Next state from TMS; the IR branch mirrors the DR branch
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms ? TLR    : RTI;
      RTI:     state_d = tms ? SEL_DR : RTI;
      SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms ? SEL_DR : RTI;
      SEL_IR:  state_d = tms ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - TAP controller top: FSM, falling-edge strobes, clock gating
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int STATE_W = TAP_STATE_W
) (
  input  logic               TCK,
  input  logic               Reset,
  input  logic               TMS,
  output logic [STATE_W-1:0] State,
  output logic               ShiftIR,
  output logic               ClockIR,
  output logic               UpdateIR,
  output logic               ShiftDR,
  output logic               ClockDR,
  output logic               UpdateDR,
  output logic               TapReset,
  output logic               Select,
  output logic               Enable
);

  tap_state_t state;

  logic tap_reset_q, tap_reset_d;
  logic shift_ir_q,  shift_ir_d;
  logic shift_dr_q,  shift_dr_d;
  logic update_ir_q, update_ir_d;
  logic update_dr_q, update_dr_d;
  logic select_q,    select_d;
  logic enable_q,    enable_d;
  logic ir_clk_en_q, ir_clk_en_d;
  logic dr_clk_en_q, dr_clk_en_d;

  jtag_tap_fsm u_fsm (
    .tck   (TCK),
    .rst   (Reset),
    .tms   (TMS),
    .state (state)
  );

  // Decode the strobes from the current state; registered on TCK fall below
  always_comb begin
    tap_reset_d = (state == TLR);
    shift_ir_d  = (state == SH_IR);
    shift_dr_d  = (state == SH_DR);
    update_ir_d = (state == UPD_IR);
    update_dr_d = (state == UPD_DR);
    select_d    = IR_BRANCH[state];
    enable_d    = (state == SH_IR) || (state == SH_DR);
    ir_clk_en_d = (state == CAP_IR) || (state == SH_IR);
    dr_clk_en_d = (state == CAP_DR) || (state == SH_DR);
  end

  // Falling-edge strobe registers: change half a cycle after the state does,
  // so each strobe is glitch-free; reset drives the TLR values immediately
  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      tap_reset_q <= 1'b1;
      shift_ir_q  <= 1'b0;
      shift_dr_q  <= 1'b0;
      update_ir_q <= 1'b0;
      update_dr_q <= 1'b0;
      select_q    <= 1'b0;
      enable_q    <= 1'b0;
      ir_clk_en_q <= 1'b0;
      dr_clk_en_q <= 1'b0;
    end else begin
      tap_reset_q <= tap_reset_d;
      shift_ir_q  <= shift_ir_d;
      shift_dr_q  <= shift_dr_d;
      update_ir_q <= update_ir_d;
      update_dr_q <= update_dr_d;
      select_q    <= select_d;
      enable_q    <= enable_d;
      ir_clk_en_q <= ir_clk_en_d;
      dr_clk_en_q <= dr_clk_en_d;
    end
  end

  // Gated register clocks idle high and follow TCK only while capturing/shifting
  assign ClockIR  = TCK | ~ir_clk_en_q;
  assign ClockDR  = TCK | ~dr_clk_en_q;

  assign State    = state;
  assign ShiftIR  = shift_ir_q;
  assign ShiftDR  = shift_dr_q;
  assign UpdateIR = update_ir_q;
  assign UpdateDR = update_dr_q;
  assign TapReset = tap_reset_q;
  assign Select   = select_q;
  assign Enable   = enable_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - self-checking bench for the TAP controller
module tb_jtag_tap_controller;

  localparam int S_EX2_DR = 0,  S_EX1_DR = 1,  S_SH_DR  = 2,  S_PAU_DR = 3;
  localparam int S_SEL_IR = 4,  S_UPD_DR = 5,  S_CAP_DR = 6,  S_SEL_DR = 7;
  localparam int S_EX2_IR = 8,  S_EX1_IR = 9,  S_SH_IR  = 10, S_PAU_IR = 11;
  localparam int S_RTI    = 12, S_UPD_IR = 13, S_CAP_IR = 14, S_TLR    = 15;

  logic       TCK, Reset, TMS;
  logic [3:0] State;
  logic       ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR;
  logic       TapReset, Select, Enable;

  int checks = 0;
  int errors = 0;

  // Reference model: transition tables filled from the state diagram
  int nxt0 [16];
  int nxt1 [16];
  int ir_list [7];
  int exp_state;
  int prev_state;
  logic [8:0] hi_outs;
  logic [3:0] hi_state;

  // Observed strobe vector; order matches exp_outs
  logic [8:0] outs;
  assign outs = {TapReset, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, Select, Enable};

  // Edge counters and a small 4-bit instruction register hung on the strobes
  int n_cir = 0, n_cdr = 0, n_uir = 0, n_udr = 0;
  logic [3:0] ir_sr, ir_q;
  logic tdi;

  jtag_tap_controller dut (
    .TCK      (TCK),
    .Reset    (Reset),
    .TMS      (TMS),
    .State    (State),
    .ShiftIR  (ShiftIR),
    .ClockIR  (ClockIR),
    .UpdateIR (UpdateIR),
    .ShiftDR  (ShiftDR),
    .ClockDR  (ClockDR),
    .UpdateDR (UpdateDR),
    .TapReset (TapReset),
    .Select   (Select),
    .Enable   (Enable)
  );

  always @(posedge ClockIR) begin
    if (TCK === 1'b1) begin
      n_cir++;
      if (ShiftIR) ir_sr <= {tdi, ir_sr[3:1]};
      else         ir_sr <= 4'b0101;
    end
  end
  always @(posedge UpdateIR or posedge TapReset) begin
    if (TapReset) ir_q <= 4'h1;
    else          ir_q <= ir_sr;
  end
  always @(posedge ClockDR) if (TCK === 1'b1) n_cdr++;
  always @(posedge UpdateIR) n_uir++;
  always @(posedge UpdateDR) n_udr++;

  task automatic init_model();
    nxt0[S_TLR]    = S_RTI;    nxt1[S_TLR]    = S_TLR;
    nxt0[S_RTI]    = S_RTI;    nxt1[S_RTI]    = S_SEL_DR;
    nxt0[S_SEL_DR] = S_CAP_DR; nxt1[S_SEL_DR] = S_SEL_IR;
    nxt0[S_CAP_DR] = S_SH_DR;  nxt1[S_CAP_DR] = S_EX1_DR;
    nxt0[S_SH_DR]  = S_SH_DR;  nxt1[S_SH_DR]  = S_EX1_DR;
    nxt0[S_EX1_DR] = S_PAU_DR; nxt1[S_EX1_DR] = S_UPD_DR;
    nxt0[S_PAU_DR] = S_PAU_DR; nxt1[S_PAU_DR] = S_EX2_DR;
    nxt0[S_EX2_DR] = S_SH_DR;  nxt1[S_EX2_DR] = S_UPD_DR;
    nxt0[S_UPD_DR] = S_RTI;    nxt1[S_UPD_DR] = S_SEL_DR;
    nxt0[S_SEL_IR] = S_CAP_IR; nxt1[S_SEL_IR] = S_TLR;
    nxt0[S_CAP_IR] = S_SH_IR;  nxt1[S_CAP_IR] = S_EX1_IR;
    nxt0[S_SH_IR]  = S_SH_IR;  nxt1[S_SH_IR]  = S_EX1_IR;
    nxt0[S_EX1_IR] = S_PAU_IR; nxt1[S_EX1_IR] = S_UPD_IR;
    nxt0[S_PAU_IR] = S_PAU_IR; nxt1[S_PAU_IR] = S_EX2_IR;
    nxt0[S_EX2_IR] = S_SH_IR;  nxt1[S_EX2_IR] = S_UPD_IR;
    nxt0[S_UPD_IR] = S_RTI;    nxt1[S_UPD_IR] = S_SEL_DR;
    ir_list = '{S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR};
  endtask

  // Expected strobes for a registered state s, with TCK at level tck
  function automatic logic [8:0] exp_outs(input int s, input bit tck);
    bit ir, ien, den;
    ir = 1'b0;
    for (int i = 0; i < 7; i++) if (ir_list[i] == s) ir = 1'b1;
    ien = (s == S_CAP_IR) || (s == S_SH_IR);
    den = (s == S_CAP_DR) || (s == S_SH_DR);
    return {s == S_TLR, s == S_SH_IR, tck | ~ien, s == S_UPD_IR,
            s == S_SH_DR, tck | ~den, s == S_UPD_DR, ir,
            (s == S_SH_IR) || (s == S_SH_DR)};
  endfunction

  // One TCK period; ends 2 time units after the falling edge
  task automatic step(input bit tms_v, input bit tdi_v);
    TMS = tms_v;
    tdi = tdi_v;
    #5 TCK = 1'b1;
    prev_state = exp_state;
    exp_state  = tms_v ? nxt1[exp_state] : nxt0[exp_state];
    #2 hi_outs = outs;
    hi_state = State;
    #3 TCK = 1'b0;
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #3 Reset = 1'b0;
    exp_state = S_TLR;
    #3;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #3;
    checks++;
    if (State !== 4'hF) begin errors++; $display("FAIL reset_state got %h want f", State); end
    checks++;
    if (outs !== exp_outs(S_TLR, 0)) begin errors++; $display("FAIL reset_outs got %b want %b", outs, exp_outs(S_TLR, 0)); end
    Reset = 1'b0;
    exp_state = S_TLR;
    #4;
    checks++;
    if (outs !== exp_outs(S_TLR, 0) || State !== 4'hF) begin
      errors++; $display("FAIL reset_release_hold got %h/%b want f/%b", State, outs, exp_outs(S_TLR, 0));
    end
  endtask

  task automatic test_ir_path();
    int   walk [5] = '{S_RTI, S_SEL_DR, S_SEL_IR, S_CAP_IR, S_SH_IR};
    bit   tmsv [5] = '{0, 1, 1, 0, 0};
    logic [3:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(tmsv[i], 1'b0);
      w = walk[i][3:0];
      checks++;
      if (State !== w) begin errors++; $display("FAIL ir_walk_state step %0d got %h want %h", i, State, w); end
      checks++;
      if (outs !== exp_outs(walk[i], 0)) begin errors++; $display("FAIL ir_walk_outs step %0d got %b want %b", i, outs, exp_outs(walk[i], 0)); end
    end
    checks++;
    if ({ShiftIR, Select, Enable, ClockIR} !== 4'b1110) begin
      errors++; $display("FAIL ir_shift_strobes got %b want 1110", {ShiftIR, Select, Enable, ClockIR});
    end
  endtask

  task automatic test_ir_update();
    bit t0, t1, t2;
    int u0;
    logic [3:0] want;
    t0 = 1'($urandom_range(0, 1)); t1 = 1'($urandom_range(0, 1)); t2 = 1'($urandom_range(0, 1));
    u0 = n_uir;
    step(1'b0, t0);
    checks++;
    if (hi_outs[6] !== 1'b1) begin errors++; $display("FAIL ir_clock_high got %b want 1", hi_outs[6]); end
    step(1'b0, t1);
    step(1'b1, t2);
    checks++;
    if (State !== 4'h9) begin errors++; $display("FAIL ir_ex1 got %h want 9", State); end
    step(1'b1, 1'b0);
    checks++;
    if (State !== 4'hD || UpdateIR !== 1'b1) begin errors++; $display("FAIL ir_upd got %h/%b want d/1", State, UpdateIR); end
    step(1'b0, 1'b0);
    checks++;
    if (UpdateIR !== 1'b0 || (n_uir - u0) != 1) begin
      errors++; $display("FAIL ir_update_pulse got level %b count %0d want 0/1", UpdateIR, n_uir - u0);
    end
    want = {t2, t1, t0, 1'b0};
    checks++;
    if (ir_q !== want) begin errors++; $display("FAIL ir_latched got %h want %h", ir_q, want); end
  endtask

  task automatic test_dr_path();
    bit tmsv [6] = '{1, 0, 0, 0, 1, 1};
    int c_dr, c_ir, u_dr;
    c_dr = n_cdr; c_ir = n_cir; u_dr = n_udr;
    for (int i = 0; i < 6; i++) begin
      step(tmsv[i], 1'b0);
      checks++;
      if (State !== exp_state[3:0] || outs !== exp_outs(exp_state, 0)) begin
        errors++; $display("FAIL dr_walk step %0d got %h/%b want %h/%b", i, State, outs, exp_state[3:0], exp_outs(exp_state, 0));
      end
    end
    checks++;
    if (State !== 4'h5) begin errors++; $display("FAIL dr_upd_state got %h want 5", State); end
    step(1'b0, 1'b0);
    checks++;
    if ((n_cdr - c_dr) != 3 || (n_cir - c_ir) != 0) begin
      errors++; $display("FAIL dr_clock_edges got dr %0d ir %0d want 3/0", n_cdr - c_dr, n_cir - c_ir);
    end
    checks++;
    if ((n_udr - u_dr) != 1) begin errors++; $display("FAIL dr_update_pulse got %0d want 1", n_udr - u_dr); end
  endtask

  task automatic test_pause();
    int c0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    checks++;
    if (State !== 4'h2 || Enable !== 1'b1) begin errors++; $display("FAIL pause_pre got %h/%b want 2/1", State, Enable); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    c0 = n_cdr;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (State !== 4'h3 || ClockDR !== 1'b1 || Enable !== 1'b0 || hi_outs[3] !== 1'b1) begin
        errors++; $display("FAIL pause_hold %0d got %h/%b/%b want 3/1/0", i, State, ClockDR, Enable);
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if (State !== 4'h0 || n_cdr != c0) begin errors++; $display("FAIL pause_ex2 got %h edges %0d want 0/0", State, n_cdr - c0); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (State !== 4'h2 || Enable !== 1'b1 || (n_cdr - c0) != 1) begin
      errors++; $display("FAIL pause_resume got %h/%b edges %0d want 2/1/1", State, Enable, n_cdr - c0);
    end
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    checks++;
    if (State !== 4'hA || ClockIR !== 1'b0) begin errors++; $display("FAIL midrst_pre got %h/%b want a/0", State, ClockIR); end
    Reset = 1'b1;
    #1;
    checks++;
    if (State !== 4'hF || TapReset !== 1'b1 || ShiftIR !== 1'b0 || ClockIR !== 1'b1) begin
      errors++; $display("FAIL midrst_async got %h/%b%b%b want f/101", State, TapReset, ShiftIR, ClockIR);
    end
    #2 Reset = 1'b0;
    exp_state = S_TLR;
    #2;
  endtask

  task automatic test_five_ones();
    int budget;
    logic [3:0] t4;
    for (int t = 0; t < 16; t++) begin
      budget = 0;
      while (exp_state != t && budget < 400) begin
        step(1'($urandom_range(0, 1)), 1'b0);
        budget++;
      end
      t4 = t[3:0];
      checks++;
      if (State !== t4) begin errors++; $display("FAIL five_ones_reach got %h want %h", State, t4); end
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      checks++;
      if (State !== 4'hF || TapReset !== 1'b1) begin
        errors++; $display("FAIL five_ones from %h got %h/%b want f/1", t4, State, TapReset);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (hi_state !== exp_state[3:0] || hi_outs !== exp_outs(prev_state, 1)) begin
        errors++; $display("FAIL rand_rise %0d got %h/%b want %h/%b", i, hi_state, hi_outs, exp_state[3:0], exp_outs(prev_state, 1));
      end
      checks++;
      if (State !== exp_state[3:0] || outs !== exp_outs(exp_state, 0)) begin
        errors++; $display("FAIL rand_fall %0d got %h/%b want %h/%b", i, State, outs, exp_state[3:0], exp_outs(exp_state, 0));
      end
    end
  endtask

  initial begin
    TCK = 1'b0; Reset = 1'b0; TMS = 1'b1; tdi = 1'b0; ir_sr = 4'h0;
    exp_state = S_TLR; prev_state = S_TLR;
    init_model();
    test_reset();
    test_ir_path();
    test_ir_update();
    test_dr_path();
    test_pause();
    test_mid_reset();
    test_five_ones();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
